project_pwm_capture: RTL and testbench
======================================

// Module: project_pwm_capture
// PURPOSE
//  Input-capture peripheral: measures period and high time of one external PWM waveform.
//  Counterpart of the PWM generator; used to loop back and check generated channels.
//  Registers are accessed through the same byte-wide write_en/address/data register-file protocol.
//  Lives beside the comparator/deadband blocks; one instance per monitored line.
// PARAMETERS
//  WIDTH          16  capture counter and result width (registers are split MSB/LSB bytes)
//  SYNC_STAGES    2   flops in the i_pwm input synchronizer (>=2)
//  ADDRESS_WIDTH  3   register address width
// PORTS
//  i_clk      in   1              single clock
//  i_reset_n  in   1              reset, asynchronous, active-low
//  i_pwm      in   1              asynchronous PWM input under measurement
//  i_write_en in   1              1 = write i_data at i_address; 0 = read
//  i_address  in   ADDRESS_WIDTH  register select
//  i_data     in   8              write data
//  o_data     out  8              registered read data
//  o_irq      out  1              level interrupt: status.valid & ctrl.irq_en
// BEHAVIOUR
//  Reset: all registers, counter, shadows and FSM cleared; o_data=0, o_irq=0, state IDLE.
//  Register map:
//   0 CTRL (rw): [0] en, [1] invert (capture on ~i_pwm), [2] irq_en, [7:3] read 0.
//   1 STAT (w1c): [0] valid, [1] overflow, [2] overrun, [3] synced input level (ro).
//   2/3 PERIOD MSB/LSB; 4/5 HIGH MSB/LSB (ro); 6,7 read 0. Writes to ro addresses ignored.
//  Read: when i_write_en=0, o_data <= reg[i_address] on the next edge (1-cycle latency).
//   Reading addr 2 (or 4) latches the matching LSB into a shadow; addr 3 (or 5) returns the shadow.
//   This makes MSB-then-LSB reads coherent even if a capture lands between them.
//  Input path: SYNC_STAGES synchronizer, then one edge-detect flop; an edge is seen SYNC_STAGES+1
//   cycles after it occurs on i_pwm. Pulses shorter than one clock are not guaranteed to be seen.
//  FSM:
//   IDLE: en=0. cnt held at 0.
//    en=1 -> ARM.
//   ARM: wait for the first rising edge, then go to HIGH with cnt<=1. Nothing is captured.
//   HIGH: cnt<=cnt+1 each cycle.
//    On a falling edge: high_reg<=cnt, then go to LOW.
//   LOW: cnt<=cnt+1.
//    On a rising edge: period_reg<=cnt, cnt<=1, valid<=1, then go to HIGH.
//    If valid was already 1 at that moment, also set overrun<=1.
//  Result: for H high and L low clocks, HIGH=H and PERIOD=H+L.
//  Saturation: cnt stops at 2^WIDTH-1 and sets overflow.
//   The next capture stores 2^WIDTH-1; the flag stays set until cleared.
//  Disable (en 1->0) in any state: next cycle go to IDLE with cnt=0.
//   Captured values and status are kept. Re-enable always re-ARMs.
//  Toggling invert while enabled forces ARM, so a false edge is not captured.
//  STAT w1c: a 1 in bit n clears that bit. If hardware sets a bit in the same cycle, the set wins.
//  o_irq is combinational from registered bits only; it is glitch-free.
// STRUCTURE
//  Shared package pwm_pkg: register address constants, CTRL/STAT bit indices, FSM state enum.
//  Sub-module project_pwm_edge_sync holds synchronizer + rise/fall pulse outputs.
//   It is reusable for future trip/sync inputs.
//  Top holds the FSM, counter, register file, shadows and read mux.
// TESTING
//  1 Write CTRL=0x01; drive i_pwm 30 high/70 low for 3 periods.
//   -> after the 2nd rising edge PERIOD=100 (0x0064) and HIGH=30; STAT.valid=1.
//  2 Same as 1 with CTRL=0x03 (invert).
//   -> HIGH=70, PERIOD=100.
//  3 Keep i_pwm low for 70000 clocks after arming.
//   -> STAT.overflow=1; next capture PERIOD=0xFFFF.
//   Write STAT=0x02 -> overflow=0.
//  4 Read addr 2 -> 0x00, let a capture change PERIOD from 100 to 300, read addr 3.
//   -> returns 0x64 (shadow), not 0x2C.
//  5 Leave valid set over two captures -> overrun=1.
//   With irq_en=1, o_irq=1; w1c 0x05 in a capture cycle -> valid stays 1, overrun cleared.
//  6 Assert i_reset_n=0 mid-HIGH, and separately clear en mid-HIGH.
//   -> reset: all regs 0, o_irq=0. Disable: IDLE; PERIOD/HIGH unchanged.
//   Re-enable: no capture until 2nd rising edge.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: register map, register layouts, FSM states.
package pwm_pkg;

  localparam int unsigned DATA_W = 8;

  localparam int unsigned ADDR_CTRL     = 0;
  localparam int unsigned ADDR_STAT     = 1;
  localparam int unsigned ADDR_PER_MSB  = 2;
  localparam int unsigned ADDR_PER_LSB  = 3;
  localparam int unsigned ADDR_HIGH_MSB = 4;
  localparam int unsigned ADDR_HIGH_LSB = 5;

  // Bit positions inside the STAT register (also used for w1c masks).
  localparam int unsigned STAT_VALID    = 0;
  localparam int unsigned STAT_OVERFLOW = 1;
  localparam int unsigned STAT_OVERRUN  = 2;
  localparam int unsigned STAT_LEVEL    = 3;

  typedef struct packed {
    logic [4:0] rsvd;
    logic       irq_en;
    logic       invert;
    logic       en;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] rsvd;
    logic       level;
    logic       overrun;
    logic       overflow;
    logic       valid;
  } stat_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_e;

endpackage

// File: rtl/project_pwm_edge_sync.sv
// Synchronizes an asynchronous level and produces one-cycle rise/fall pulses.
module project_pwm_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/project_pwm_capture.sv
// PWM input capture: measures period and high time of one external waveform,
// exposed through a byte-wide register file with coherent MSB/LSB reads.
module project_pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned ADDRESS_WIDTH = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_pwm,
  input  logic                     i_write_en,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [7:0]               i_data,
  output logic [7:0]               o_data,
  output logic                     o_irq
);

  localparam int unsigned  REG_W   = 16;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_inc_c, period_q, high_q;
  logic             at_max_c, cap_high_c, cap_period_c, sat_c;
  ctrl_t            ctrl_q;
  logic             inv_seen_q;
  logic             valid_q, overflow_q, overrun_q;
  logic [7:0]       per_shadow_q, high_shadow_q, rd_mux_c;
  logic [REG_W-1:0] per_reg_c, high_reg_c;
  logic             level, rise_c, fall_c, rise_eff_c, fall_eff_c;
  logic             wr_ctrl_c, wr_stat_c;
  logic [2:0]       w1c_c;
  logic             unused_c;
  stat_t            stat_c;

  project_pwm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk     (i_clk),
    .rst_n   (i_reset_n),
    .async_in(i_pwm),
    .level   (level),
    .rise_c  (rise_c),
    .fall_c  (fall_c)
  );

  assign rise_eff_c = ctrl_q.invert ? fall_c : rise_c;
  assign fall_eff_c = ctrl_q.invert ? rise_c : fall_c;
  assign at_max_c   = (cnt_q == CNT_MAX);
  assign cnt_inc_c  = at_max_c ? cnt_q : cnt_q + WIDTH'(1);

  assign wr_ctrl_c  = i_write_en && (i_address == ADDRESS_WIDTH'(ADDR_CTRL));
  assign wr_stat_c  = i_write_en && (i_address == ADDRESS_WIDTH'(ADDR_STAT));
  assign w1c_c      = wr_stat_c ? i_data[2:0] : 3'b000;
  assign unused_c   = ^i_data[7:3];

  assign per_reg_c  = REG_W'(period_q);
  assign high_reg_c = REG_W'(high_q);
  assign o_irq      = valid_q & ctrl_q.irq_en;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and capture strobes; disable and invert changes override everything.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_high_c   = 1'b0;
    cap_period_c = 1'b0;
    sat_c        = 1'b0;
    if (!ctrl_q.en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (ctrl_q.invert != inv_seen_q) begin
      state_d = ST_ARM;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end
        ST_ARM: begin
          if (rise_eff_c) begin
            state_d = ST_HIGH;
            cnt_d   = WIDTH'(1);
          end
        end
        ST_HIGH: begin
          cnt_d = cnt_inc_c;
          sat_c = at_max_c;
          if (fall_eff_c) begin
            cap_high_c = 1'b1;
            state_d    = ST_LOW;
          end
        end
        ST_LOW: begin
          if (rise_eff_c) begin
            cap_period_c = 1'b1;
            cnt_d        = WIDTH'(1);
            state_d      = ST_HIGH;
          end else begin
            cnt_d = cnt_inc_c;
            sat_c = at_max_c;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stat_c          = '0;
    stat_c.valid    = valid_q;
    stat_c.overflow = overflow_q;
    stat_c.overrun  = overrun_q;
    stat_c.level    = level;
  end

  always_comb begin
    rd_mux_c = 8'h00;
    case (i_address)
      ADDRESS_WIDTH'(ADDR_CTRL):     rd_mux_c = ctrl_q;
      ADDRESS_WIDTH'(ADDR_STAT):     rd_mux_c = stat_c;
      ADDRESS_WIDTH'(ADDR_PER_MSB):  rd_mux_c = per_reg_c[15:8];
      ADDRESS_WIDTH'(ADDR_PER_LSB):  rd_mux_c = per_shadow_q;
      ADDRESS_WIDTH'(ADDR_HIGH_MSB): rd_mux_c = high_reg_c[15:8];
      ADDRESS_WIDTH'(ADDR_HIGH_LSB): rd_mux_c = high_shadow_q;
      default:                       rd_mux_c = 8'h00;
    endcase
  end

  // Register file, status flags (hardware set beats w1c) and read path with LSB shadows.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ctrl_q        <= '0;
      inv_seen_q    <= 1'b0;
      period_q      <= '0;
      high_q        <= '0;
      valid_q       <= 1'b0;
      overflow_q    <= 1'b0;
      overrun_q     <= 1'b0;
      per_shadow_q  <= 8'h00;
      high_shadow_q <= 8'h00;
      o_data        <= 8'h00;
    end else begin
      if (wr_ctrl_c) begin
        ctrl_q <= ctrl_t'({5'b00000, i_data[2:0]});
      end
      inv_seen_q <= ctrl_q.invert;
      if (cap_high_c) begin
        high_q <= cnt_q;
      end
      if (cap_period_c) begin
        period_q <= cnt_q;
      end
      valid_q    <= cap_period_c | (valid_q & ~w1c_c[STAT_VALID]);
      overflow_q <= sat_c | (overflow_q & ~w1c_c[STAT_OVERFLOW]);
      overrun_q  <= (cap_period_c & valid_q) | (overrun_q & ~w1c_c[STAT_OVERRUN]);
      if (!i_write_en) begin
        o_data <= rd_mux_c;
        if (i_address == ADDRESS_WIDTH'(ADDR_PER_MSB)) begin
          per_shadow_q <= per_reg_c[7:0];
        end
        if (i_address == ADDRESS_WIDTH'(ADDR_HIGH_MSB)) begin
          high_shadow_q <= high_reg_c[7:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_project_pwm_capture.sv
// Directed bench for project_pwm_capture: register reads checked against a vector table
// plus hand sequences for shadow reads, w1c races, disable and reset.
module tb_project_pwm_capture;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_pwm;
  logic       i_write_en;
  logic [2:0] i_address;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic       o_irq;

  always #5 i_clk = ~i_clk;

  project_pwm_capture #(
    .WIDTH        (16),
    .SYNC_STAGES  (2),
    .ADDRESS_WIDTH(3)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_pwm     (i_pwm),
    .i_write_en(i_write_en),
    .i_address (i_address),
    .i_data    (i_data),
    .o_data    (o_data),
    .o_irq     (o_irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // PWM source: gen_hi clocks high then gen_lo clocks low, changed at falling clock edges.
  bit gen_on = 1'b0;
  int gen_hi = 30;
  int gen_lo = 70;
  int ph     = 0;

  initial begin
    i_pwm = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!gen_on) begin
        i_pwm = 1'b0;
        ph    = 0;
      end else begin
        i_pwm = (ph < gen_hi);
        ph    = (ph + 1 >= gen_hi + gen_lo) ? 0 : ph + 1;
      end
    end
  end

  typedef struct {
    int         phase;
    logic [2:0] addr;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(int p, logic [2:0] a, logic [7:0] e, string nm);
    vec_t v;
    v.phase = p;
    v.addr  = a;
    v.exp   = e;
    v.name  = nm;
    vecs.push_back(v);
  endfunction

  task automatic check8(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
    end
  endtask

  task automatic check1(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic write_reg(logic [2:0] a, logic [7:0] d);
    @(negedge i_clk);
    i_write_en = 1'b1;
    i_address  = a;
    i_data     = d;
    @(negedge i_clk);
    i_write_en = 1'b0;
    i_address  = 3'd0;
    i_data     = 8'h00;
  endtask

  task automatic read_reg(logic [2:0] a, output logic [7:0] d);
    @(negedge i_clk);
    i_write_en = 1'b0;
    i_address  = a;
    @(negedge i_clk);
    d         = o_data;
    i_address = 3'd0;
  endtask

  task automatic run_phase(int p);
    logic [7:0] d;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].phase == p) begin
        read_reg(vecs[i].addr, d);
        check8(vecs[i].name, d, vecs[i].exp);
      end
    end
  endtask

  task automatic start_gen(int hi, int lo);
    gen_hi = hi;
    gen_lo = lo;
    gen_on = 1'b1;
    repeat (3) @(negedge i_clk);
  endtask

  // Returns on the first rising clock edge that sees a fresh 0->1 of i_pwm.
  task automatic wait_rise();
    logic prev;
    bit   found;
    prev  = i_pwm;
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(posedge i_clk);
      if (i_pwm && !prev) found = 1'b1;
      prev = i_pwm;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL rise_timeout: got none expected a pwm rising edge");
    end
  endtask

  task automatic wait_rises(int n);
    repeat (n) wait_rise();
    repeat (6) @(negedge i_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;

    add_vec(1, 3'd1, 8'h09, "t1_stat");   add_vec(1, 3'd2, 8'h00, "t1_per_msb");
    add_vec(1, 3'd3, 8'h64, "t1_per_lsb"); add_vec(1, 3'd4, 8'h00, "t1_high_msb");
    add_vec(1, 3'd5, 8'h1E, "t1_high_lsb"); add_vec(1, 3'd0, 8'h01, "t1_ctrl");
    add_vec(2, 3'd1, 8'h09, "t2_stat");   add_vec(2, 3'd2, 8'h00, "t2_per_msb");
    add_vec(2, 3'd3, 8'h64, "t2_per_lsb"); add_vec(2, 3'd4, 8'h00, "t2_high_msb");
    add_vec(2, 3'd5, 8'h46, "t2_high_lsb"); add_vec(2, 3'd0, 8'h03, "t2_ctrl");
    add_vec(3, 3'd1, 8'h02, "t3_stat_ovf_low");
    add_vec(4, 3'd1, 8'h0B, "t3_stat_cap"); add_vec(4, 3'd2, 8'hFF, "t3_per_msb");
    add_vec(4, 3'd3, 8'hFF, "t3_per_lsb"); add_vec(4, 3'd4, 8'h00, "t3_high_msb");
    add_vec(4, 3'd5, 8'h28, "t3_high_lsb");
    add_vec(5, 3'd1, 8'h09, "t3_stat_ovf_clr");
    add_vec(6, 3'd1, 8'h0D, "t4_stat_overrun"); add_vec(6, 3'd2, 8'h01, "t4_per_msb");
    add_vec(6, 3'd3, 8'h2C, "t4_per_lsb"); add_vec(6, 3'd4, 8'h00, "t4_high_msb");
    add_vec(6, 3'd5, 8'h1E, "t4_high_lsb");
    add_vec(7, 3'd2, 8'h01, "t6_dis_per_msb"); add_vec(7, 3'd3, 8'h2C, "t6_dis_per_lsb");
    add_vec(7, 3'd4, 8'h00, "t6_dis_high_msb"); add_vec(7, 3'd5, 8'h1E, "t6_dis_high_lsb");
    add_vec(7, 3'd0, 8'h04, "t6_dis_ctrl");
    add_vec(8, 3'd1, 8'h08, "t6_rearm_stat"); add_vec(8, 3'd2, 8'h01, "t6_rearm_per_msb");
    add_vec(8, 3'd3, 8'h2C, "t6_rearm_per_lsb");
    add_vec(9, 3'd1, 8'h09, "t6_recap_stat"); add_vec(9, 3'd2, 8'h00, "t6_recap_per_msb");
    add_vec(9, 3'd3, 8'h64, "t6_recap_per_lsb"); add_vec(9, 3'd4, 8'h00, "t6_recap_high_msb");
    add_vec(9, 3'd5, 8'h1E, "t6_recap_high_lsb"); add_vec(9, 3'd0, 8'h01, "t6_recap_ctrl");
    add_vec(10, 3'd0, 8'h00, "rst_ctrl");   add_vec(10, 3'd1, 8'h00, "rst_stat");
    add_vec(10, 3'd2, 8'h00, "rst_per_msb"); add_vec(10, 3'd3, 8'h00, "rst_per_lsb");
    add_vec(10, 3'd4, 8'h00, "rst_high_msb"); add_vec(10, 3'd5, 8'h00, "rst_high_lsb");
    add_vec(10, 3'd6, 8'h00, "rst_addr6");  add_vec(10, 3'd7, 8'h00, "rst_addr7");

    i_reset_n  = 1'b0;
    i_write_en = 1'b0;
    i_address  = 3'd0;
    i_data     = 8'h00;
    repeat (3) @(negedge i_clk);
    check8("reset_o_data", o_data, 8'h00);
    check1("reset_o_irq", o_irq, 1'b0);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // Basic capture, 30 high / 70 low.
    write_reg(3'd0, 8'h01);
    start_gen(30, 70);
    wait_rises(1);
    run_phase(1);
    check1("t1_irq_off", o_irq, 1'b0);
    write_reg(3'd0, 8'h00);
    gen_on = 1'b0;
    write_reg(3'd1, 8'h07);

    // Inverted capture.
    write_reg(3'd0, 8'h03);
    start_gen(30, 70);
    wait_rises(2);
    run_phase(2);
    write_reg(3'd0, 8'h00);
    gen_on = 1'b0;
    write_reg(3'd1, 8'h07);

    // Counter saturation over a very long low phase.
    write_reg(3'd0, 8'h01);
    start_gen(40, 70000);
    repeat (66500) @(negedge i_clk);
    run_phase(3);
    wait_rises(1);
    run_phase(4);
    write_reg(3'd1, 8'h02);
    run_phase(5);
    write_reg(3'd0, 8'h00);
    gen_on = 1'b0;
    write_reg(3'd1, 8'h07);

    // Shadowed LSB: period changes 100 -> 300 between MSB and LSB reads.
    write_reg(3'd0, 8'h01);
    start_gen(30, 70);
    wait_rises(1);
    read_reg(3'd2, d);
    check8("t4_msb_before", d, 8'h00);
    gen_lo = 270;
    wait_rises(1);
    read_reg(3'd3, d);
    check8("t4_lsb_shadow", d, 8'h64);
    run_phase(6);

    // Overrun, irq and w1c landing in the capture cycle.
    write_reg(3'd0, 8'h05);
    check1("t5_irq_on", o_irq, 1'b1);
    write_reg(3'd1, 8'h01);
    check1("t5_irq_cleared", o_irq, 1'b0);
    wait_rise();
    @(negedge i_clk);
    write_reg(3'd1, 8'h05);
    repeat (3) @(negedge i_clk);
    check1("t5_irq_after_race", o_irq, 1'b1);
    read_reg(3'd1, d);
    check8("t5_stat_after_race", d, 8'h09);

    // Disable mid-HIGH, then re-enable.
    wait_rise();
    repeat (10) @(negedge i_clk);
    write_reg(3'd0, 8'h04);
    gen_lo = 70;
    repeat (40) @(negedge i_clk);
    run_phase(7);
    check1("t6_dis_irq", o_irq, 1'b1);
    write_reg(3'd1, 8'h07);
    check1("t6_dis_irq_clr", o_irq, 1'b0);
    write_reg(3'd0, 8'h01);
    wait_rises(1);
    run_phase(8);
    wait_rises(1);
    run_phase(9);

    // Asynchronous reset mid-HIGH.
    write_reg(3'd0, 8'h05);
    check1("t6_pre_reset_irq", o_irq, 1'b1);
    wait_rise();
    repeat (10) @(negedge i_clk);
    i_reset_n = 1'b0;
    gen_on    = 1'b0;
    repeat (2) @(negedge i_clk);
    check8("t6_reset_o_data", o_data, 8'h00);
    check1("t6_reset_o_irq", o_irq, 1'b0);
    i_reset_n = 1'b1;
    repeat (5) @(negedge i_clk);
    write_reg(3'd2, 8'hFF);
    run_phase(10);
    check1("t6_post_reset_irq", o_irq, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
